// File: rtl/ysyx_22050133_fetch_queue_pkg.sv
// Shared fetch-queue definitions: data widths, reset PC, FSM encodings and queue entry layout.
package ysyx_22050133_fetch_queue_pkg;

   localparam int unsigned XLEN = 64;
   localparam int unsigned ILEN = 32;

   localparam logic [XLEN-1:0] NPC_RESET_PC = 64'h0000_0000_8000_0000;

   localparam logic [1:0] ST_REQ   = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_STALL = 2'd2;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] inst;
   } fq_entry_t;

endpackage

// File: rtl/ysyx_22050133_sync_fifo.sv
// Synchronous FIFO with flush; storage resets to zero so the head reads zero out of reset.
module ysyx_22050133_sync_fifo #(
   parameter int unsigned WIDTH = 96,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         head_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign do_push   = push & ~full & ~flush;
   assign do_pop    = pop & ~empty & ~flush;
   assign head_data = mem[rd_ptr];

   // Pointers and occupancy; flush wins over any push/pop in the same cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/ysyx_22050133_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, keeps one imem request in flight,
// buffers {pc, inst} in a small queue and handles redirects by flushing and dropping.
module ysyx_22050133_fetch_queue
   import ysyx_22050133_fetch_queue_pkg::*;
#(
   parameter logic [63:0]  RESET_PC = NPC_RESET_PC,
   parameter int unsigned  DEPTH    = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [63:0]     redirect_pc,
   output logic            imem_req_valid,
   output logic [63:0]     imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_resp_valid,
   input  logic [31:0]     imem_resp_inst,
   output logic            out_valid,
   output logic [63:0]     out_pc,
   output logic [31:0]     out_inst,
   input  logic            out_ready
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [1:0]       state;
   logic [1:0]       state_n;
   logic [XLEN-1:0]  fetch_pc;
   logic [XLEN-1:0]  fetch_pc_n;
   logic [XLEN-1:0]  inflight_pc;
   logic [XLEN-1:0]  inflight_pc_n;
   logic             drop;
   logic             drop_n;

   logic             req_fire;
   logic             push;
   logic             pop;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_n;
   logic             full;
   logic             empty;
   fq_entry_t        push_entry;
   fq_entry_t        head_entry;

   // Request is a function of registered state only; held low while in reset
   assign imem_req_valid = ~rst & (state == ST_REQ) & ~full;
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid & imem_req_ready;

   assign push       = ~redirect_valid & (state == ST_WAIT) & imem_resp_valid & ~drop;
   assign pop        = ~redirect_valid & ~empty & out_ready;
   assign count_n    = count + CNT_W'(push) - CNT_W'(pop);
   assign push_entry = '{pc: inflight_pc, inst: imem_resp_inst};

   assign out_valid = ~empty;
   assign out_pc    = head_entry.pc;
   assign out_inst  = head_entry.inst;

   ysyx_22050133_sync_fifo #(
      .WIDTH ($bits(fq_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .flush     (redirect_valid),
      .head_data (head_entry),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_REQ;
         fetch_pc    <= RESET_PC;
         inflight_pc <= '0;
         drop        <= 1'b0;
      end else begin
         state       <= state_n;
         fetch_pc    <= fetch_pc_n;
         inflight_pc <= inflight_pc_n;
         drop        <= drop_n;
      end
   end

   // Next-state: a redirect overrides everything, otherwise the REQ/WAIT/STALL walk
   always_comb begin
      state_n       = state;
      fetch_pc_n    = fetch_pc;
      inflight_pc_n = inflight_pc;
      drop_n        = drop;

      if (redirect_valid) begin
         fetch_pc_n = redirect_pc;
         if ((state == ST_WAIT) && imem_resp_valid) begin
            state_n = ST_REQ;
            drop_n  = 1'b0;
         end else if ((state == ST_WAIT) || req_fire) begin
            state_n = ST_WAIT;
            drop_n  = 1'b1;
         end else begin
            state_n = ST_REQ;
         end
      end else begin
         case (state)
            ST_REQ: begin
               if (full) begin
                  state_n = ST_STALL;
               end else if (req_fire) begin
                  inflight_pc_n = fetch_pc;
                  fetch_pc_n    = fetch_pc + XLEN'(4);
                  state_n       = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (imem_resp_valid) begin
                  drop_n  = 1'b0;
                  state_n = (count_n < CNT_W'(DEPTH)) ? ST_REQ : ST_STALL;
               end
            end
            ST_STALL: begin
               if (count < CNT_W'(DEPTH)) state_n = ST_REQ;
            end
            default: state_n = ST_REQ;
         endcase
      end
   end

endmodule
